softmc_pcie_bridge: RTL and testbench

SOFTMC_PCIE_BRIDGE -- requirements
Module: softmc_pcie_bridge

---
 rtl/softmc_pcie_bridge_if.sv | 58 +++++
 rtl/softmc_pcie_bridge.sv | 151 +++++++++++++++
 tb/tb_softmc_pcie_bridge.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/softmc_pcie_bridge_if.sv
// RIFFA channel, instruction stream and readback FIFO bundle between the PCIe bridge and its neighbours.
// slave = bridge side, master = host/memory-controller side.
interface softmc_pcie_bridge_if #(
    parameter int W = 32,
    parameter int R = 256
);
    logic          CHNL_RX_CLK;
    logic          CHNL_RX;
    logic          CHNL_RX_ACK;
    logic          CHNL_RX_LAST;
    logic [31:0]   CHNL_RX_LEN;
    logic [30:0]   CHNL_RX_OFF;
    logic [W-1:0]  CHNL_RX_DATA;
    logic          CHNL_RX_DATA_VALID;
    logic          CHNL_RX_DATA_REN;

    logic          CHNL_TX_CLK;
    logic          CHNL_TX;
    logic          CHNL_TX_ACK;
    logic          CHNL_TX_LAST;
    logic [31:0]   CHNL_TX_LEN;
    logic [30:0]   CHNL_TX_OFF;
    logic [W-1:0]  CHNL_TX_DATA;
    logic          CHNL_TX_DATA_VALID;
    logic          CHNL_TX_DATA_REN;

    logic          app_en;
    logic [31:0]   app_instr;
    logic          app_ack;

    logic          rdback_fifo_empty;
    logic          rdback_fifo_rden;
    logic [R-1:0]  rdback_data;

    modport slave (
        input  CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF, CHNL_RX_DATA, CHNL_RX_DATA_VALID,
        output CHNL_RX_CLK, CHNL_RX_ACK, CHNL_RX_DATA_REN,
        output CHNL_TX_CLK, CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF, CHNL_TX_DATA,
        output CHNL_TX_DATA_VALID,
        input  CHNL_TX_ACK, CHNL_TX_DATA_REN,
        output app_en, app_instr,
        input  app_ack,
        input  rdback_fifo_empty, rdback_data,
        output rdback_fifo_rden
    );

    modport master (
        output CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF, CHNL_RX_DATA, CHNL_RX_DATA_VALID,
        input  CHNL_RX_CLK, CHNL_RX_ACK, CHNL_RX_DATA_REN,
        input  CHNL_TX_CLK, CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF, CHNL_TX_DATA,
        input  CHNL_TX_DATA_VALID,
        output CHNL_TX_ACK, CHNL_TX_DATA_REN,
        input  app_en, app_instr,
        output app_ack,
        output rdback_fifo_empty, rdback_data,
        input  rdback_fifo_rden
    );
endinterface

// File: rtl/softmc_pcie_bridge.sv
// RIFFA <-> SoftMC bridge: RX beats split into 32-bit instructions via a FIFO; readback words sent as TX bursts.
// Latency: RX beat to app_en 2 cycles; readback entry to first TX beat 1 cycle. Backpressure: RX REN drops
// while the holding register cannot drain; TX holds data until CHNL_TX_DATA_REN. SOFTMC_RDBACK_TRUNC_EN: 1-beat TX.
module softmc_pcie_bridge #(
    parameter int C_PCI_DATA_WIDTH = 32,
    parameter int DQ_WIDTH         = 64,
    parameter int INSTR_FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    softmc_pcie_bridge_if.slave  bus
);
    localparam int W      = C_PCI_DATA_WIDTH;
    localparam int R      = 4 * DQ_WIDTH;
    localparam int K      = W / 32;
    localparam int LANE_W = (K > 1) ? $clog2(K) : 1;
    localparam int AW     = (INSTR_FIFO_DEPTH > 1) ? $clog2(INSTR_FIFO_DEPTH) : 1;
    localparam int PW     = AW + 1;
`ifdef SOFTMC_RDBACK_TRUNC_EN
    localparam int NB     = 1;
`else
    localparam int NB     = R / W;
`endif
    localparam int SH_W   = NB * W;
    localparam int CNT_W  = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic {IDLE, SEND} tx_state_e;

    logic              rx_q, rx_d, rx_ack_q, rx_ack_d;
    logic              hold_vld_q, hold_vld_d;
    logic [W-1:0]      hold_dat_q, hold_dat_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fifo_cnt;
    logic [31:0]       mem_q [2**AW];
    logic              fifo_full, fifo_empty, push, pop, last_lane, rx_ren, rx_acc;
    tx_state_e         state_q, state_d;
    logic [SH_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rden;
    logic              unused_in;

    always_comb begin
        rx_d       = bus.CHNL_RX;
        rx_ack_d   = bus.CHNL_RX & ~rx_q;
        fifo_cnt   = wr_ptr_q - rd_ptr_q;
        fifo_full  = (fifo_cnt == PW'(INSTR_FIFO_DEPTH));
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        // Full is derived from registered pointers, so a same-cycle pop never frees room for a push.
        push       = hold_vld_q & ~fifo_full;
        pop        = ~fifo_empty & bus.app_ack;
        last_lane  = (lane_q == LANE_W'(K - 1));
        rx_ren     = ~hold_vld_q | (push & last_lane);
        rx_acc     = bus.CHNL_RX_DATA_VALID & rx_ren;
        hold_vld_d = hold_vld_q;
        hold_dat_d = hold_dat_q;
        lane_d     = lane_q;
        if (push) begin
            if (last_lane) begin
                hold_vld_d = 1'b0;
                lane_d     = '0;
            end else begin
                hold_dat_d = hold_dat_q >> 32;
                lane_d     = lane_q + LANE_W'(1);
            end
        end
        if (rx_acc) begin
            hold_dat_d = bus.CHNL_RX_DATA;
            hold_vld_d = 1'b1;
            lane_d     = '0;
        end
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        rden    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.rdback_fifo_empty) begin
                    rden    = 1'b1;
                    shift_d = bus.rdback_data[SH_W-1:0];
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.CHNL_TX_DATA_REN) begin
                    shift_d = shift_q >> W;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NB - 1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q       <= 1'b0;
            rx_ack_q   <= 1'b0;
            hold_vld_q <= 1'b0;
            hold_dat_q <= '0;
            lane_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
        end else begin
            rx_q       <= rx_d;
            rx_ack_q   <= rx_ack_d;
            hold_vld_q <= hold_vld_d;
            hold_dat_q <= hold_dat_d;
            lane_q     <= lane_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= hold_dat_q[31:0];
        end
    end

    assign bus.CHNL_RX_CLK        = clk;
    assign bus.CHNL_RX_ACK        = rx_ack_q;
    assign bus.CHNL_RX_DATA_REN   = rx_ren;
    assign bus.CHNL_TX_CLK        = clk;
    assign bus.CHNL_TX            = (state_q == SEND);
    assign bus.CHNL_TX_DATA_VALID = (state_q == SEND);
    assign bus.CHNL_TX_DATA       = shift_q[W-1:0];
    assign bus.CHNL_TX_LEN        = 32'(SH_W / 32);
    assign bus.CHNL_TX_OFF        = '0;
    assign bus.CHNL_TX_LAST       = 1'b1;
    assign bus.app_en             = ~fifo_empty;
    assign bus.app_instr          = mem_q[rd_ptr_q[AW-1:0]];
    assign bus.rdback_fifo_rden   = rden & ~rst;

    // RX framing fields and TX ACK carry nothing this bridge acts on.
    assign unused_in = ^{bus.CHNL_RX_LAST, bus.CHNL_RX_LEN, bus.CHNL_RX_OFF, bus.CHNL_TX_ACK,
                         bus.rdback_data};
endmodule

// File: tb/tb_softmc_pcie_bridge.sv
// Directed bench for softmc_pcie_bridge (W=64, DQ=64, depth 16) with instruction and TX scoreboards.
module tb_softmc_pcie_bridge;
    localparam int W = 64;
    localparam int R = 256;
`ifdef SOFTMC_RDBACK_TRUNC_EN
    localparam int NB = 1;
`else
    localparam int NB = 4;
`endif
    localparam int EXP_LEN = NB * W / 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    softmc_pcie_bridge_if #(.W(W), .R(R)) bus();

    softmc_pcie_bridge #(
        .C_PCI_DATA_WIDTH(W),
        .DQ_WIDTH(64),
        .INSTR_FIFO_DEPTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] iq[$];
    logic [63:0] tq[$];
    int          rdb_cnt = 0;
    int          rden_pulses = 0;
    int          tx_accepted = 0;
    logic [63:0] rw[4];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: monitor at negedge, then advance to just after the next posedge.
    task automatic cyc();
        logic rden_now, tx_acc;
        @(negedge clk);
        if (!rst) begin
            if (bus.app_en) begin
                if (iq.size() == 0) chk("instr_unexpected", 256'(bus.app_en), 256'(1'b0));
                else if (bus.app_ack) chk("instr_pop", 256'(bus.app_instr), 256'(iq.pop_front()));
                else chk("instr_hold", 256'(bus.app_instr), 256'(iq[0]));
            end
            if (bus.CHNL_TX_DATA_VALID) begin
                chk("tx_req", 256'(bus.CHNL_TX), 256'(1'b1));
                if (tq.size() == 0) chk("tx_unexpected", 256'(bus.CHNL_TX_DATA_VALID), 256'(1'b0));
                else if (bus.CHNL_TX_DATA_REN) chk("tx_beat", 256'(bus.CHNL_TX_DATA), 256'(tq.pop_front()));
                else chk("tx_stall_hold", 256'(bus.CHNL_TX_DATA), 256'(tq[0]));
            end
            if (bus.rdback_fifo_empty) chk("rden_when_empty", 256'(bus.rdback_fifo_rden), 256'(1'b0));
        end
        rden_now = bus.rdback_fifo_rden;
        tx_acc   = bus.CHNL_TX_DATA_VALID & bus.CHNL_TX_DATA_REN;
        @(posedge clk);
        #1;
        if (rden_now) begin
            rden_pulses++;
            if (rdb_cnt > 0) rdb_cnt--;
        end
        if (tx_acc && !rst) tx_accepted++;
        bus.rdback_fifo_empty = (rdb_cnt == 0);
    endtask

    task automatic send_beat(input logic [63:0] d);
        bit ok;
        ok = 1'b0;
        bus.CHNL_RX_DATA       = d;
        bus.CHNL_RX_DATA_VALID = 1'b1;
        iq.push_back(d[31:0]);
        iq.push_back(d[63:32]);
        for (int i = 0; i < 200 && !ok; i++) begin
            ok = bus.CHNL_RX_DATA_REN;
            cyc();
        end
        bus.CHNL_RX_DATA_VALID = 1'b0;
        if (!ok) chk("rx_beat_timeout", 256'(bus.CHNL_RX_DATA_REN), 256'(1'b1));
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && iq.size() != 0; i++) cyc();
        chk(tag, 256'(iq.size()), 256'(0));
        cyc();
        chk("app_en_after_drain", 256'(bus.app_en), 256'(1'b0));
    endtask

    task automatic load_rdback();
        bus.rdback_data = {rw[3], rw[2], rw[1], rw[0]};
        rdb_cnt = 1;
        bus.rdback_fifo_empty = 1'b0;
        for (int i = 0; i < NB; i++) tq.push_back(rw[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int stall;
        int target;
        bit len_seen;
        rw[0] = 64'h0000_0000_DEAD_0000;
        rw[1] = 64'h1111_1111_DEAD_0001;
        rw[2] = 64'h2222_2222_DEAD_0002;
        rw[3] = 64'h3333_3333_DEAD_0003;
        rst = 1'b1;
        bus.CHNL_RX = 1'b0;  bus.CHNL_RX_LAST = 1'b1; bus.CHNL_RX_LEN = '0; bus.CHNL_RX_OFF = '0;
        bus.CHNL_RX_DATA = '0; bus.CHNL_RX_DATA_VALID = 1'b0;
        bus.CHNL_TX_ACK = 1'b0; bus.CHNL_TX_DATA_REN = 1'b0; bus.app_ack = 1'b0;
        bus.rdback_fifo_empty = 1'b1; bus.rdback_data = '0;
        @(posedge clk);
        #1;
        repeat (2) cyc();

        chk("rst_rx_ack", 256'(bus.CHNL_RX_ACK), 256'(1'b0));
        chk("rst_tx", 256'(bus.CHNL_TX), 256'(1'b0));
        chk("rst_tx_valid", 256'(bus.CHNL_TX_DATA_VALID), 256'(1'b0));
        chk("rst_app_en", 256'(bus.app_en), 256'(1'b0));
        chk("rst_rden", 256'(bus.rdback_fifo_rden), 256'(1'b0));
        rst = 1'b0;
        cyc();
        chk("ren_after_reset", 256'(bus.CHNL_RX_DATA_REN), 256'(1'b1));
        chk("rx_clk_follows_clk", 256'(bus.CHNL_RX_CLK), 256'(clk));

        // CHNL_RX rising edge -> one-cycle ACK one cycle later
        bus.CHNL_RX = 1'b1;
        chk("rx_ack_before", 256'(bus.CHNL_RX_ACK), 256'(1'b0));
        cyc();
        chk("rx_ack_pulse", 256'(bus.CHNL_RX_ACK), 256'(1'b1));
        cyc();
        chk("rx_ack_single", 256'(bus.CHNL_RX_ACK), 256'(1'b0));
        cyc();
        chk("rx_ack_stays_low", 256'(bus.CHNL_RX_ACK), 256'(1'b0));

        // single beat split into two instructions, lane 0 first, held until ack
        send_beat(64'h00000002_00000001);
        repeat (4) cyc();
        chk("first_instr_lane0", 256'(bus.app_instr), 256'(32'h00000001));
        bus.app_ack = 1'b1;
        drain("single_beat_drain");

        // fill FIFO with ack held low; ninth beat parks in holding register
        bus.app_ack = 1'b0;
        for (int b = 0; b < 9; b++)
            send_beat({32'(32'h100 + 2 * b + 1), 32'(32'h100 + 2 * b)});
        repeat (4) cyc();
        chk("ren_low_when_full", 256'(bus.CHNL_RX_DATA_REN), 256'(1'b0));
        chk("app_en_when_full", 256'(bus.app_en), 256'(1'b1));
        chk("instr_queue_depth", 256'(iq.size()), 256'(18));
        bus.app_ack = 1'b1;
        drain("full_fifo_drain");

        // readback burst with a 3-cycle REN stall on beat 2
        load_rdback();
        tx_accepted = 0;
        rden_pulses = 0;
        stall = 0;
        len_seen = 1'b0;
        for (int i = 0; i < 60 && tq.size() != 0; i++) begin
            if (NB > 2 && tx_accepted == 2 && stall < 3) begin
                bus.CHNL_TX_DATA_REN = 1'b0;
                stall++;
            end else begin
                bus.CHNL_TX_DATA_REN = 1'b1;
            end
            if (bus.CHNL_TX && !len_seen) begin
                len_seen = 1'b1;
                chk("tx_len", 256'(bus.CHNL_TX_LEN), 256'(EXP_LEN));
                chk("tx_off", 256'(bus.CHNL_TX_OFF), 256'(0));
                chk("tx_last", 256'(bus.CHNL_TX_LAST), 256'(1'b1));
            end
            cyc();
        end
        chk("tx_queue_empty", 256'(tq.size()), 256'(0));
        chk("tx_low_after_burst", 256'(bus.CHNL_TX), 256'(1'b0));
        chk("tx_beats_accepted", 256'(tx_accepted), 256'(NB));
        repeat (2) cyc();
        chk("rden_single_pulse", 256'(rden_pulses), 256'(1));
        chk("tx_idle_no_entry", 256'(bus.CHNL_TX), 256'(1'b0));

        // reset in the middle of a burst with an instruction pending
        bus.app_ack = 1'b0;
        send_beat(64'hAAAA_0004_AAAA_0003);
        load_rdback();
        tx_accepted = 0;
        target = (NB > 2) ? 2 : 0;
        bus.CHNL_TX_DATA_REN = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (tx_accepted == target && bus.CHNL_TX) break;
            cyc();
        end
        chk("tx_active_before_rst", 256'(bus.CHNL_TX), 256'(1'b1));
        bus.CHNL_TX_DATA_REN = 1'b0;
        rst = 1'b1;
        cyc();
        chk("rst_mid_tx", 256'(bus.CHNL_TX), 256'(1'b0));
        chk("rst_mid_tx_valid", 256'(bus.CHNL_TX_DATA_VALID), 256'(1'b0));
        chk("rst_mid_app_en", 256'(bus.app_en), 256'(1'b0));
        chk("rst_mid_rden", 256'(bus.rdback_fifo_rden), 256'(1'b0));
        rst = 1'b0;
        iq.delete();
        tq.delete();
        cyc();
        chk("ren_after_mid_reset", 256'(bus.CHNL_RX_DATA_REN), 256'(1'b1));
        repeat (3) cyc();
        chk("fifo_empty_after_reset", 256'(bus.app_en), 256'(1'b0));
        chk("tx_idle_after_reset", 256'(bus.CHNL_TX), 256'(1'b0));

        // back-to-back beats with the consumer always ready
        bus.app_ack = 1'b1;
        send_beat(64'h5000_0002_5000_0001);
        send_beat(64'h5000_0004_5000_0003);
        send_beat(64'h5000_0006_5000_0005);
        drain("stream_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
